// File: rtl/iq_comp_pkg.sv
// Shared definitions for the adaptive IQ compensator: operating modes, settle FSM states
// and a generic signed saturation helper.
package iq_comp_pkg;

   localparam logic [1:0] BYPASS = 2'b00;
   localparam logic [1:0] INT_W  = 2'b01;
   localparam logic [1:0] EXT_W  = 2'b10;
   localparam logic [1:0] CONT_W = 2'b11;

   typedef enum logic [1:0] {
      StIdle,
      StAdapt,
      StSettled,
      StHold
   } settle_state_e;

   // Clamp a signed value to the range of a signed 'width'-bit quantity.
   function automatic logic signed [63:0] sat(input logic signed [63:0] value,
                                              input int                width);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (width - 1)) - 64'sd1;
      lo = -hi - 64'sd1;
      if (value > hi) return hi;
      if (value < lo) return lo;
      return value;
   endfunction

endpackage

// File: rtl/iq_comp_settle_det.sv
// Convergence detector: counts consecutive quiet W updates and flags settled, with a hold
// state that freezes the count while the internal adaptation is frozen.
module iq_comp_settle_det
   import iq_comp_pkg::*;
#(
   parameter int D_W        = 14,
   parameter int SETTLE_TH  = 2,
   parameter int SETTLE_WIN = 64
) (
   input  logic                  clk,
   input  logic                  RESETn,
   input  logic                  upd,
   input  logic signed [D_W-1:0] dwr,
   input  logic signed [D_W-1:0] dwj,
   input  logic [1:0]            mode,
   input  logic                  freeze,
   output logic                  settled
);

   localparam int CNT_W = $clog2(SETTLE_WIN + 1);

   settle_state_e    state_q, prior_q, cur;
   logic [CNT_W-1:0] cnt_q;
   logic [1:0]       mode_q;
   logic             settled_q;
   logic             quiet, adapt_mode, hold_req;

   always_comb begin
      quiet      = (int'(dwr) <= SETTLE_TH) && (int'(dwr) >= -SETTLE_TH) &&
                   (int'(dwj) <= SETTLE_TH) && (int'(dwj) >= -SETTLE_TH);
      adapt_mode = (mode == INT_W) || (mode == CONT_W);
      hold_req   = (mode == INT_W) && freeze;
      // Leaving HOLD behaves as the remembered state so an update on that edge still counts.
      cur        = (state_q == StHold && !freeze) ? prior_q : state_q;
   end

   always_ff @(posedge clk or negedge RESETn) begin
      if (!RESETn) begin
         state_q   <= StIdle;
         prior_q   <= StAdapt;
         cnt_q     <= '0;
         mode_q    <= BYPASS;
         settled_q <= 1'b0;
      end else begin
         mode_q <= mode;
         if (mode != mode_q || !adapt_mode) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            settled_q <= 1'b0;
         end else begin
            case (cur)
               StIdle: begin
                  state_q <= StAdapt;
                  if (upd) cnt_q <= quiet ? CNT_W'(1) : '0;
               end
               StAdapt, StSettled: begin
                  if (hold_req) begin
                     prior_q <= cur;
                     state_q <= StHold;
                  end else begin
                     state_q <= cur;
                     if (upd) begin
                        if (quiet) begin
                           if (cnt_q != CNT_W'(SETTLE_WIN)) cnt_q <= cnt_q + CNT_W'(1);
                           if (cur == StAdapt && cnt_q == CNT_W'(SETTLE_WIN - 1)) begin
                              state_q   <= StSettled;
                              settled_q <= 1'b1;
                           end
                        end else begin
                           state_q   <= StAdapt;
                           cnt_q     <= '0;
                           settled_q <= 1'b0;
                        end
                     end
                  end
               end
               default: state_q <= StHold;
            endcase
         end
      end
   end

   assign settled = settled_q;

endmodule

// File: rtl/iq_comp_adaptive.sv
// Adaptive 2x2 IQ image-rejection compensator: offset-binary to signed conversion,
// saturated correction with W, and LMS-style W adaptation with a settle detector.
module iq_comp_adaptive
   import iq_comp_pkg::*;
#(
   parameter int IN_W       = 4,
   parameter int W_W        = 13,
   parameter int M          = 9,
   parameter int UPD_SHIFT  = 0,
   parameter int SETTLE_TH  = 2,
   parameter int SETTLE_WIN = 64
) (
   input  logic                   clk,
   input  logic                   RESETn,
   input  logic                   in_valid,
   input  logic [1:0]             op_mode,
   input  logic                   freeze_iqcomp,
   input  logic [IN_W-1:0]        Ix,
   input  logic [IN_W-1:0]        Qx,
   input  logic signed [W_W-1:0]  Wr_in,
   input  logic signed [W_W-1:0]  Wj_in,
   output logic                   out_valid,
   output logic signed [IN_W-1:0] Iy,
   output logic signed [IN_W-1:0] Qy,
   output logic signed [W_W-1:0]  Wr,
   output logic signed [W_W-1:0]  Wj,
   output logic                   settled
);

   localparam int ACC_W = IN_W + W_W + 2;
   localparam int UPD_W = W_W + 2 * IN_W + 4;
   localparam int D_W   = W_W + 1;

   logic signed [IN_W-1:0]  ix_s, qx_s, iy_d, qy_d, iy_q, qy_q;
   logic signed [W_W-1:0]   wr_use, wj_use, wr_upd, wj_upd, wr_d, wj_d, wr_q, wj_q;
   logic signed [ACC_W-1:0] acc_i, acc_q;
   logic signed [UPD_W-1:0] sum_s, dif_s, term_r, term_j;
   logic signed [D_W-1:0]   dwr, dwj;
   logic                    out_valid_q, upd;

   always_comb begin
      // Offset-binary to two's complement is an MSB flip.
      ix_s   = {~Ix[IN_W-1], Ix[IN_W-2:0]};
      qx_s   = {~Qx[IN_W-1], Qx[IN_W-2:0]};
      wr_use = (op_mode == EXT_W) ? Wr_in : wr_q;
      wj_use = (op_mode == EXT_W) ? Wj_in : wj_q;

      acc_i = (ACC_W'(ix_s) <<< M) + ACC_W'(wr_use) * ACC_W'(ix_s)
              + ACC_W'(wj_use) * ACC_W'(qx_s);
      acc_q = (ACC_W'(qx_s) <<< M) + ACC_W'(wj_use) * ACC_W'(ix_s)
              - ACC_W'(wr_use) * ACC_W'(qx_s);

      if (op_mode == BYPASS) begin
         iy_d = ix_s;
         qy_d = qx_s;
      end else begin
         iy_d = IN_W'(sat(64'(acc_i >>> M), IN_W));
         qy_d = IN_W'(sat(64'(acc_q >>> M), IN_W));
      end
   end

   // Adaptation works from the registered outputs, so W lags the sample it corrects by one.
   always_comb begin
      sum_s  = UPD_W'(iy_q) + UPD_W'(qy_q);
      dif_s  = UPD_W'(iy_q) - UPD_W'(qy_q);
      term_r = (sum_s * dif_s) >>> UPD_SHIFT;
      term_j = ((UPD_W'(iy_q) * UPD_W'(qy_q)) <<< 1) >>> UPD_SHIFT;
      wr_upd = W_W'(sat(64'(UPD_W'(wr_q) - term_r), W_W));
      wj_upd = W_W'(sat(64'(UPD_W'(wj_q) - term_j), W_W));
      dwr    = D_W'(wr_upd) - D_W'(wr_q);
      dwj    = D_W'(wj_upd) - D_W'(wj_q);
      upd    = in_valid && out_valid_q &&
               ((op_mode == CONT_W) || (op_mode == INT_W && !freeze_iqcomp));

      case (op_mode)
         BYPASS: begin
            wr_d = '0;
            wj_d = '0;
         end
         EXT_W: begin
            wr_d = Wr_in;
            wj_d = Wj_in;
         end
         default: begin
            wr_d = upd ? wr_upd : wr_q;
            wj_d = upd ? wj_upd : wj_q;
         end
      endcase
   end

   always_ff @(posedge clk or negedge RESETn) begin
      if (!RESETn) begin
         out_valid_q <= 1'b0;
         iy_q        <= '0;
         qy_q        <= '0;
         wr_q        <= '0;
         wj_q        <= '0;
      end else begin
         out_valid_q <= in_valid;
         if (in_valid) begin
            iy_q <= iy_d;
            qy_q <= qy_d;
         end
         wr_q <= wr_d;
         wj_q <= wj_d;
      end
   end

   iq_comp_settle_det #(
      .D_W        (D_W),
      .SETTLE_TH  (SETTLE_TH),
      .SETTLE_WIN (SETTLE_WIN)
   ) u_settle_det (
      .clk     (clk),
      .RESETn  (RESETn),
      .upd     (upd),
      .dwr     (dwr),
      .dwj     (dwj),
      .mode    (op_mode),
      .freeze  (freeze_iqcomp),
      .settled (settled)
   );

   assign out_valid = out_valid_q;
   assign Iy        = iy_q;
   assign Qy        = qy_q;
   assign Wr        = wr_q;
   assign Wj        = wj_q;

endmodule

// File: tb/tb_iq_comp_adaptive.sv
// Bench for iq_comp_adaptive: directed scenarios plus randomized traffic, every cycle
// compared against an arithmetic reference model.
module tb_iq_comp_adaptive;

   localparam int IN_W       = 4;
   localparam int W_W        = 13;
   localparam int M          = 9;
   localparam int UPD_SHIFT  = 0;
   localparam int SETTLE_TH  = 2;
   localparam int SETTLE_WIN = 8;

   logic                   clk = 1'b0;
   logic                   RESETn = 1'b1;
   logic                   in_valid = 1'b0;
   logic [1:0]             op_mode = 2'b00;
   logic                   freeze_iqcomp = 1'b0;
   logic [IN_W-1:0]        Ix = '0;
   logic [IN_W-1:0]        Qx = '0;
   logic signed [W_W-1:0]  Wr_in = '0;
   logic signed [W_W-1:0]  Wj_in = '0;
   logic                   out_valid;
   logic signed [IN_W-1:0] Iy, Qy;
   logic signed [W_W-1:0]  Wr, Wj;
   logic                   settled;

   int n_tests = 0;
   int n_fail  = 0;

   longint     m_wr, m_wj, m_iy, m_qy;
   bit         m_ov, m_settled;
   int         m_run;
   logic [1:0] m_prev;

   iq_comp_adaptive #(
      .IN_W       (IN_W),
      .W_W        (W_W),
      .M          (M),
      .UPD_SHIFT  (UPD_SHIFT),
      .SETTLE_TH  (SETTLE_TH),
      .SETTLE_WIN (SETTLE_WIN)
   ) dut (
      .clk           (clk),
      .RESETn        (RESETn),
      .in_valid      (in_valid),
      .op_mode       (op_mode),
      .freeze_iqcomp (freeze_iqcomp),
      .Ix            (Ix),
      .Qx            (Qx),
      .Wr_in         (Wr_in),
      .Wj_in         (Wj_in),
      .out_valid     (out_valid),
      .Iy            (Iy),
      .Qy            (Qy),
      .Wr            (Wr),
      .Wj            (Wj),
      .settled       (settled)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input longint obs, input longint exp);
      n_tests++;
      if (obs != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   function automatic longint fdiv(input longint a, input longint d);
      longint q;
      q = a / d;
      if ((a % d != 0) && ((a < 0) != (d < 0))) q = q - 1;
      return q;
   endfunction

   function automatic longint clamp(input longint v, input int w);
      longint hi, lo;
      hi = (longint'(1) << (w - 1)) - 1;
      lo = -hi - 1;
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
   endfunction

   task automatic model_reset();
      m_wr = 0; m_wj = 0; m_iy = 0; m_qy = 0;
      m_ov = 1'b0; m_settled = 1'b0; m_run = 0; m_prev = 2'b00;
   endtask

   // Advance the reference by one clock using the currently driven inputs.
   task automatic model_step();
      longint ix, qx, wr_use, wj_use, i_new, q_new, wr_n, wj_n;
      bit     upd, adapt;
      ix     = longint'(Ix) - (longint'(1) << (IN_W - 1));
      qx     = longint'(Qx) - (longint'(1) << (IN_W - 1));
      wr_use = (op_mode == 2'b10) ? longint'(Wr_in) : m_wr;
      wj_use = (op_mode == 2'b10) ? longint'(Wj_in) : m_wj;
      if (op_mode == 2'b00) begin
         i_new = ix;
         q_new = qx;
      end else begin
         i_new = clamp(ix + fdiv(wr_use * ix + wj_use * qx, longint'(1) << M), IN_W);
         q_new = clamp(qx + fdiv(wj_use * ix - wr_use * qx, longint'(1) << M), IN_W);
      end
      adapt = (op_mode == 2'b01) || (op_mode == 2'b11);
      upd   = in_valid && m_ov && (op_mode == 2'b11 || (op_mode == 2'b01 && !freeze_iqcomp));
      wr_n  = m_wr;
      wj_n  = m_wj;
      if (op_mode == 2'b00) begin
         wr_n = 0; wj_n = 0;
      end else if (op_mode == 2'b10) begin
         wr_n = longint'(Wr_in); wj_n = longint'(Wj_in);
      end else if (upd) begin
         wr_n = clamp(m_wr - fdiv((m_iy + m_qy) * (m_iy - m_qy), longint'(1) << UPD_SHIFT), W_W);
         wj_n = clamp(m_wj - fdiv(2 * m_iy * m_qy, longint'(1) << UPD_SHIFT), W_W);
      end
      if (op_mode != m_prev || !adapt) m_run = 0;
      else if (upd) begin
         if (wr_n - m_wr <= SETTLE_TH && m_wr - wr_n <= SETTLE_TH &&
             wj_n - m_wj <= SETTLE_TH && m_wj - wj_n <= SETTLE_TH) m_run++;
         else m_run = 0;
      end
      m_settled = (m_run >= SETTLE_WIN);
      m_prev    = op_mode;
      if (in_valid) begin
         m_iy = i_new;
         m_qy = q_new;
      end
      m_ov = in_valid;
      m_wr = wr_n;
      m_wj = wj_n;
   endtask

   task automatic cycle(input string tag);
      model_step();
      @(posedge clk);
      #1;
      check({tag, "_ov"}, longint'(out_valid), longint'(m_ov));
      check({tag, "_iy"}, longint'(Iy), m_iy);
      check({tag, "_qy"}, longint'(Qy), m_qy);
      check({tag, "_wr"}, longint'(Wr), m_wr);
      check({tag, "_wj"}, longint'(Wj), m_wj);
      check({tag, "_settled"}, longint'(settled), longint'(m_settled));
   endtask

   // Asserts reset between edges and expects every output to clear before the next edge.
   task automatic apply_reset(input string tag);
      RESETn = 1'b0;
      #1;
      check({tag, "_ov"}, longint'(out_valid), 0);
      check({tag, "_iy"}, longint'(Iy), 0);
      check({tag, "_qy"}, longint'(Qy), 0);
      check({tag, "_wr"}, longint'(Wr), 0);
      check({tag, "_wj"}, longint'(Wj), 0);
      check({tag, "_settled"}, longint'(settled), 0);
      model_reset();
      @(negedge clk);
      RESETn = 1'b1;
   endtask

   initial begin
      longint saved_iy, saved_wr, prev_wr;
      bit     calm;

      #1;
      apply_reset("rst");

      // Bypass: offset removal only.
      op_mode = 2'b00; in_valid = 1'b1; Ix = 4'd12; Qx = 4'd3;
      cycle("byp");
      check("byp_iy_val", longint'(Iy), 4);
      check("byp_qy_val", longint'(Qy), -5);
      check("byp_ov_val", longint'(out_valid), 1);
      check("byp_wr_val", longint'(Wr), 0);

      // External W of exactly unity gain correction.
      op_mode = 2'b10; Wr_in = 13'sd512; Wj_in = 13'sd0; Ix = 4'd10; Qx = 4'd8;
      cycle("ext1");
      check("ext1_iy_val", longint'(Iy), 4);
      check("ext1_qy_val", longint'(Qy), 0);
      Ix = 4'd15;
      cycle("ext2");
      check("ext2_iy_sat", longint'(Iy), 7);

      // Internal adaptation from reset.
      apply_reset("rst2");
      op_mode = 2'b01; Ix = 4'd12; Qx = 4'd8; in_valid = 1'b1;
      cycle("int1");
      check("int1_iy_val", longint'(Iy), 4);
      cycle("int2");
      check("int2_wr_val", longint'(Wr), -16);
      check("int2_iy_val", longint'(Iy), 4);
      cycle("int3");
      check("int3_wr_val", longint'(Wr), -32);
      check("int3_iy_val", longint'(Iy), 3);
      check("int3_wj_val", longint'(Wj), 0);
      freeze_iqcomp = 1'b1;
      for (int k = 0; k < 3; k++) begin
         cycle("frz");
         check("frz_wr_held", longint'(Wr), -32);
      end
      op_mode = 2'b11;
      prev_wr = -32;
      for (int k = 0; k < 3; k++) begin
         cycle("cont");
         check("cont_wr_dec", longint'(Wr < prev_wr), 1);
         prev_wr = longint'(Wr);
      end

      // Reset in the middle of continuous adaptation.
      apply_reset("async");
      freeze_iqcomp = 1'b0;

      // Settle: zero error input gives quiet updates.
      op_mode = 2'b01; Ix = 4'd8; Qx = 4'd8; in_valid = 1'b1;
      for (int k = 1; k <= 9; k++) begin
         cycle("settle");
         if (k == 8) check("settle_pre", longint'(settled), 0);
         if (k == 9) check("settle_on", longint'(settled), 1);
      end
      Ix = 4'd15;
      cycle("unsettle1");
      check("unsettle_still", longint'(settled), 1);
      cycle("unsettle2");
      check("unsettle_off", longint'(settled), 0);

      // Valid gap: outputs and W hold.
      Ix = 4'd13; Qx = 4'd6; in_valid = 1'b1;
      cycle("gap1");
      saved_iy = longint'(Iy);
      in_valid = 1'b0; Ix = 4'd3;
      cycle("gap2");
      saved_wr = longint'(Wr);
      check("gap_ov_low", longint'(out_valid), 0);
      check("gap_iy_hold", longint'(Iy), saved_iy);
      in_valid = 1'b1;
      cycle("gap3");
      check("gap_ov_high", longint'(out_valid), 1);
      check("gap_wr_hold", longint'(Wr), saved_wr);

      // Randomized traffic.
      calm = 1'b0;
      for (int n = 0; n < 1200; n++) begin
         if (n % 64 == 0) calm = ($urandom_range(0, 1) == 1);
         if ($urandom_range(0, 15) == 0) op_mode = 2'($urandom_range(0, 3));
         in_valid      = ($urandom_range(0, 3) != 0);
         freeze_iqcomp = ($urandom_range(0, 7) == 0);
         if (calm) begin
            Ix = IN_W'($urandom_range(7, 9));
            Qx = IN_W'($urandom_range(7, 9));
         end else begin
            Ix = IN_W'($urandom_range(0, 15));
            Qx = IN_W'($urandom_range(0, 15));
         end
         Wr_in = W_W'($urandom_range(0, 8191));
         Wj_in = W_W'($urandom_range(0, 8191));
         cycle("rnd");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
